// File: rtl/fft_frame_sequencer.sv
// Frame sequencer between the UART byte stream and the FFT core.
// Packs bytes into samples, runs the FFT, streams bins back out.
module fft_frame_sequencer #(
  parameter int N           = 256,
  parameter int ADDR_W      = 8,
  parameter int IN_W        = 16,
  parameter int BIT_WIDTH   = 26,
  parameter int RX_TIMEOUT  = 500000,
  parameter int FFT_TIMEOUT = 1000000
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid,
  output logic                 wr_en,
  output logic [ADDR_W-1:0]    wr_addr,
  output logic [IN_W-1:0]      wr_data,
  output logic                 fft_start,
  input  logic                 fft_done,
  output logic                 rd_en,
  output logic [ADDR_W-1:0]    rd_addr,
  input  logic [BIT_WIDTH-1:0] rd_re,
  input  logic [BIT_WIDTH-1:0] rd_im,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic                 busy,
  output logic                 frame_err,
  output logic [2:0]           state_o
);

  localparam int RXC_W = $clog2(RX_TIMEOUT + 1);
  localparam int FTC_W = $clog2(FFT_TIMEOUT + 1);
  localparam logic [ADDR_W:0] LAST =
    (ADDR_W+1)'(N - 1);
  localparam logic [RXC_W-1:0] RX_LAST =
    RXC_W'(RX_TIMEOUT - 1);
  localparam logic [FTC_W-1:0] FT_LAST =
    FTC_W'(FFT_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_RX    = 3'd0,
    S_START = 3'd1,
    S_WAIT  = 3'd2,
    S_READ  = 3'd3,
    S_LATCH = 3'd4,
    S_SEND  = 3'd5
  } state_t;

  state_t            r_state;
  logic              r_byte_idx;
  logic [7:0]        r_lo;
  logic [ADDR_W:0]   r_cnt;
  logic [ADDR_W:0]   r_k;
  logic [RXC_W-1:0]  r_idle;
  logic [FTC_W-1:0]  r_tcnt;
  logic [63:0]       r_shift;
  logic [2:0]        r_bidx;

  logic [31:0]       w_re32;
  logic [31:0]       w_im32;
  logic              w_partial;
  logic [ADDR_W:0]   w_k_nxt;

  assign w_re32 = {{(32-BIT_WIDTH){rd_re[BIT_WIDTH-1]}}, rd_re};
  assign w_im32 = {{(32-BIT_WIDTH){rd_im[BIT_WIDTH-1]}}, rd_im};
  assign w_partial = (r_cnt != '0) || r_byte_idx;
  assign w_k_nxt = r_k + (ADDR_W+1)'(1);
  assign state_o = r_state;

  // Frame control FSM; every output is a register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state    <= S_RX;
      r_byte_idx <= 1'b0;
      r_lo       <= '0;
      r_cnt      <= '0;
      r_k        <= '0;
      r_idle     <= '0;
      r_tcnt     <= '0;
      r_shift    <= '0;
      r_bidx     <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      fft_start  <= 1'b0;
      rd_en      <= 1'b0;
      rd_addr    <= '0;
      tx_data    <= '0;
      tx_valid   <= 1'b0;
      busy       <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      wr_en     <= 1'b0;
      fft_start <= 1'b0;
      rd_en     <= 1'b0;
      frame_err <= 1'b0;
      unique case (r_state)
        S_RX: begin
          if (rx_valid) begin
            r_idle <= '0;
            if (!r_byte_idx) begin
              r_lo       <= rx_data;
              r_byte_idx <= 1'b1;
            end else begin
              r_byte_idx <= 1'b0;
              wr_en      <= 1'b1;
              wr_addr    <= r_cnt[ADDR_W-1:0];
              wr_data    <= IN_W'({rx_data, r_lo});
              if (r_cnt == LAST) begin
                r_cnt   <= '0;
                busy    <= 1'b1;
                r_state <= S_START;
              end else begin
                r_cnt <= r_cnt + (ADDR_W+1)'(1);
              end
            end
          end else if (w_partial) begin
            if (r_idle == RX_LAST) begin
              frame_err  <= 1'b1;
              r_idle     <= '0;
              r_cnt      <= '0;
              r_byte_idx <= 1'b0;
            end else begin
              r_idle <= r_idle + RXC_W'(1);
            end
          end
        end
        S_START: begin
          fft_start <= 1'b1;
          r_tcnt    <= '0;
          r_state   <= S_WAIT;
        end
        S_WAIT: begin
          if (fft_done) begin
            r_k     <= '0;
            rd_en   <= 1'b1;
            rd_addr <= '0;
            r_state <= S_READ;
          end else if (r_tcnt == FT_LAST) begin
            frame_err <= 1'b1;
            busy      <= 1'b0;
            r_idle    <= '0;
            r_state   <= S_RX;
          end else begin
            r_tcnt <= r_tcnt + FTC_W'(1);
          end
        end
        S_READ: begin
          r_state <= S_LATCH;
        end
        S_LATCH: begin
          r_shift  <= {w_im32, w_re32};
          tx_data  <= w_re32[7:0];
          tx_valid <= 1'b1;
          r_bidx   <= '0;
          r_state  <= S_SEND;
        end
        S_SEND: begin
          if (tx_ready) begin
            if (r_bidx == 3'd7) begin
              tx_valid <= 1'b0;
              if (r_k == LAST) begin
                r_k        <= '0;
                r_cnt      <= '0;
                r_byte_idx <= 1'b0;
                r_idle     <= '0;
                busy       <= 1'b0;
                r_state    <= S_RX;
              end else begin
                r_k     <= w_k_nxt;
                rd_en   <= 1'b1;
                rd_addr <= w_k_nxt[ADDR_W-1:0];
                r_state <= S_READ;
              end
            end else begin
              r_bidx  <= r_bidx + 3'd1;
              r_shift <= r_shift >> 8;
              tx_data <= r_shift[15:8];
            end
          end
        end
        default: r_state <= S_RX;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Bench for fft_frame_sequencer: queue model of writes, reads
// and UART bytes, checked on every cycle, plus directed scenarios.
module tb_fft_frame_sequencer;
  localparam int N    = 8;
  localparam int AW   = 3;
  localparam int IW   = 16;
  localparam int BW   = 26;
  localparam int RXT  = 100;
  localparam int FFTT = 200;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic [7:0]    rx_data = '0;
  logic          rx_valid = 1'b0;
  logic          fft_done = 1'b0;
  logic          tx_ready = 1'b1;
  logic [BW-1:0] rd_re = '0;
  logic [BW-1:0] rd_im = '0;
  logic          wr_en, fft_start, rd_en;
  logic          tx_valid, busy, frame_err;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [IW-1:0] wr_data;
  logic [7:0]    tx_data;
  logic [2:0]    state_o;

  fft_frame_sequencer #(
    .N(N), .ADDR_W(AW), .IN_W(IW), .BIT_WIDTH(BW),
    .RX_TIMEOUT(RXT), .FFT_TIMEOUT(FFTT)
  ) dut (
    .CLK(CLK), .RST(RST),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .fft_start(fft_start), .fft_done(fft_done),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_re(rd_re), .rd_im(rd_im),
    .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .busy(busy),
    .frame_err(frame_err), .state_o(state_o)
  );

  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;
  int mode = 0;
  int ready_mode = 0;
  int cyc = 0;
  int n_wr = 0, n_rd = 0, n_tx = 0;
  int n_start = 0, n_err = 0, n_stall = 0;
  logic       p_stall = 1'b0;
  logic [7:0] p_data = '0;

  int         exp_wa[$];
  logic [15:0] exp_wd[$];
  int         exp_rd[$];
  logic [7:0] exp_tx[$];
  logic [15:0] wr_log[$];
  logic [7:0] tx_log[$];

  task automatic chk(string name, logic [63:0] act,
                     logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic miss(string name);
    tests++;
    fails++;
    $display("FAIL %s: event not seen within bound", name);
  endtask

  function automatic logic [BW-1:0] bin_re(int k);
    if (mode == 0) return 26'h3FFFFFF;
    return BW'(32'h2A00000 + k * 32'h0135791);
  endfunction

  function automatic logic [BW-1:0] bin_im(int k);
    if (mode == 0) return 26'h0000005;
    return BW'(-(k + 3));
  endfunction

  // Output-buffer model: data appears one cycle after rd_en.
  always @(posedge CLK) begin
    if (rd_en) begin
      rd_re <= bin_re(int'(rd_addr));
      rd_im <= bin_im(int'(rd_addr));
    end
  end

  // TX backpressure: always ready, or ready one cycle in three.
  initial forever begin
    @(posedge CLK);
    #1;
    cyc++;
    tx_ready = (ready_mode == 0) ? 1'b1 : ((cyc % 3) == 0);
  end

  // Expected bins: each component as a signed 32-bit value, LSB first.
  task automatic push_bins();
    for (int k = 0; k < N; k++) begin
      int v;
      int r;
      logic [31:0] w;
      exp_rd.push_back(k);
      for (int c = 0; c < 2; c++) begin
        r = (c == 0) ? int'(bin_re(k)) : int'(bin_im(k));
        v = (r >= (1 << (BW - 1))) ? r - (1 << BW) : r;
        w = v;
        for (int b = 0; b < 4; b++)
          exp_tx.push_back(8'(w >> (8 * b)));
      end
    end
  endtask

  // Compare process: every cycle, against the queues.
  initial forever begin
    @(negedge CLK);
    if (RST) begin
      p_stall = 1'b0;
    end else begin
      if (p_stall) begin
        chk("tx_hold_valid", tx_valid, 1);
        chk("tx_hold_data", tx_data, p_data);
      end
      if (wr_en) begin
        n_wr++;
        wr_log.push_back(wr_data);
        if (exp_wa.size() == 0) begin
          miss("wr_expected");
        end else begin
          chk("wr_addr", wr_addr, exp_wa.pop_front());
          chk("wr_data", wr_data, exp_wd.pop_front());
        end
      end
      if (rd_en) begin
        n_rd++;
        if (exp_rd.size() == 0) miss("rd_expected");
        else chk("rd_addr", rd_addr, exp_rd.pop_front());
      end
      if (tx_valid && tx_ready) begin
        n_tx++;
        tx_log.push_back(tx_data);
        if (exp_tx.size() == 0) miss("tx_expected");
        else chk("tx_byte", tx_data, exp_tx.pop_front());
      end
      if (tx_valid && !tx_ready) n_stall++;
      if (fft_start) n_start++;
      if (frame_err) n_err++;
      p_stall = tx_valid && !tx_ready;
      p_data  = tx_data;
    end
  end

  task automatic tick();
    @(negedge CLK);
    #2;
  endtask

  task automatic send_byte(logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge CLK);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(logic [15:0] base);
    logic [15:0] d;
    for (int i = 0; i < N; i++) begin
      d = base + 16'(i);
      exp_wa.push_back(i);
      exp_wd.push_back(d);
      send_byte(d[7:0]);
      send_byte(d[15:8]);
    end
  endtask

  task automatic wait_start();
    bit seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (fft_start) seen = 1;
    end
    if (!seen) miss("fft_start");
  endtask

  task automatic pulse_done(int n);
    repeat (n) @(posedge CLK);
    #1 fft_done = 1'b1;
    @(posedge CLK);
    #1 fft_done = 1'b0;
  endtask

  task automatic wait_idle(string name);
    bit seen = 0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      tick();
      if (state_o == 3'd0) seen = 1;
    end
    if (!seen) miss(name);
  endtask

  task automatic flush();
    exp_wa.delete();
    exp_wd.delete();
    exp_rd.delete();
    exp_tx.delete();
  endtask

  task automatic check_empty(string name);
    chk(name, exp_wa.size() + exp_rd.size() + exp_tx.size(), 0);
  endtask

  initial begin
    logic [7:0] lit [8];
    int t0, s0, e0, r0, cnt;
    bit seen;
    lit = '{8'hFF, 8'hFF, 8'hFF, 8'hFF,
            8'h05, 8'h00, 8'h00, 8'h00};

    repeat (3) @(negedge CLK);
    chk("rst_state", state_o, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wr", {wr_en, wr_addr, wr_data}, 0);
    chk("rst_tx", {tx_valid, tx_data}, 0);
    chk("rst_rd", {rd_en, rd_addr}, 0);
    chk("rst_pulse", {fft_start, frame_err}, 0);
    @(posedge CLK);
    #1 RST = 1'b0;
    @(posedge CLK);
    #1;

    // 1: full frame of samples 1..8
    s0 = n_start;
    send_frame(16'h0001);
    wait_start();
    chk("t1_busy", busy, 1);
    chk("t1_state", state_o, 2);
    tick();
    chk("t1_nstart", n_start - s0, 1);
    chk("t1_nwr", wr_log.size(), 8);
    chk("t1_wr0", wr_log[0], 16'h0001);
    chk("t1_wr7", wr_log[7], 16'h0008);

    // 2: constant bins, TX always ready
    mode = 0;
    push_bins();
    tx_log.delete();
    t0 = n_tx;
    r0 = n_rd;
    pulse_done(50);
    wait_idle("t2_idle");
    chk("t2_ntx", n_tx - t0, 64);
    chk("t2_nrd", n_rd - r0, 8);
    for (int b = 0; b < 8; b++)
      chk($sformatf("t2_lit%0d", b), tx_log[b], lit[b]);
    chk("t2_lit63", tx_log[63], 8'h00);
    chk("t2_busy", busy, 0);
    check_empty("t2_left");

    // 3: varied bins, TX ready one cycle in three
    mode = 1;
    ready_mode = 1;
    t0 = n_tx;
    send_frame(16'h1230);
    wait_start();
    push_bins();
    pulse_done(50);
    wait_idle("t3_idle");
    chk("t3_ntx", n_tx - t0, 64);
    chk("t3_stalls", n_stall > 0, 1);
    check_empty("t3_left");
    ready_mode = 0;
    mode = 0;

    // 4: partial frame then silence
    e0 = n_err;
    s0 = n_start;
    @(posedge CLK);
    #1;
    exp_wa.push_back(0);
    exp_wd.push_back(16'h2211);
    exp_wa.push_back(1);
    exp_wd.push_back(16'h4433);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h44);
    send_byte(8'h55);
    cnt = 0;
    seen = 0;
    for (int i = 0; i < 150 && !seen; i++) begin
      @(negedge CLK);
      #2;
      cnt++;
      if (frame_err) seen = 1;
    end
    if (!seen) miss("t4_frame_err");
    chk("t4_tmo_cycles", cnt, 101);
    tick();
    chk("t4_nerr", n_err - e0, 1);
    chk("t4_nstart", n_start - s0, 0);
    chk("t4_state", state_o, 0);

    // 5: clean frame, FFT never finishes
    e0 = n_err;
    r0 = n_rd;
    @(posedge CLK);
    #1;
    send_frame(16'h0A00);
    wait_start();
    check_empty("t5_wr_left");
    cnt = 0;
    seen = 0;
    for (int i = 0; i < 300 && !seen; i++) begin
      tick();
      cnt++;
      if (frame_err) seen = 1;
    end
    if (!seen) miss("t5_frame_err");
    chk("t5_tmo_cycles", cnt, 200);
    chk("t5_state", state_o, 0);
    chk("t5_busy", busy, 0);
    tick();
    chk("t5_nerr", n_err - e0, 1);
    chk("t5_nrd", n_rd - r0, 0);

    // 6: reset in the middle of bin 3
    t0 = n_tx;
    @(posedge CLK);
    #1;
    send_frame(16'h0500);
    wait_start();
    push_bins();
    pulse_done(50);
    seen = 0;
    for (int i = 0; i < 500 && !seen; i++) begin
      tick();
      if (n_tx - t0 >= 26) seen = 1;
    end
    if (!seen) miss("t6_reach_bin3");
    chk("t6_in_send", state_o, 5);
    RST = 1'b1;
    #1;
    chk("t6_rst_txv", tx_valid, 0);
    chk("t6_rst_state", state_o, 0);
    chk("t6_rst_busy", busy, 0);
    flush();
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    @(posedge CLK);
    #1;
    t0 = n_tx;
    send_frame(16'h0300);
    wait_start();
    push_bins();
    pulse_done(50);
    wait_idle("t6_idle");
    chk("t6_ntx", n_tx - t0, 64);
    check_empty("t6_left");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fft_frame_sequencer.md
Name: fft_frame_sequencer

Overview:
Controller that sequences the FFT core for the UART-fed spectrum path. It assembles incoming UART bytes into N-sample frames and writes them into the FFT input buffer. It then pulses the FFT start, waits for completion, and reads every output bin back, serialising each bin as bytes to the UART transmitter. It sits between the UART RX/TX blocks and the FFT core/buffer inside the top-level design.

Parameters:
N, 256, FFT length in samples (power of 2)
ADDR_W, 8, log2(N); width of buffer addresses
IN_W, 16, input sample width; two bytes per sample, little-endian
BIT_WIDTH, 26, width of each FFT output component (re, im)
RX_TIMEOUT, 500000, idle cycles allowed between bytes inside a partial frame
FFT_TIMEOUT, 1000000, maximum cycles in WAIT_FFT

Ports:
CLK  input  1  system clock, all logic on rising edge
RST  input  1  asynchronous, active-high reset
rx_data  input  8  received byte from UART RX
rx_valid  input  1  one-cycle strobe, rx_data valid
wr_en  output  1  input-buffer write strobe
wr_addr  output  ADDR_W  input-buffer write address
wr_data  output  IN_W  sample to write
fft_start  output  1  one-cycle FFT start pulse
fft_done  input  1  FFT complete (level or pulse; first high cycle counts)
rd_en  output  1  output-buffer read strobe
rd_addr  output  ADDR_W  output bin address
rd_re  input  BIT_WIDTH  bin real part, valid 1 cycle after rd_en
rd_im  input  BIT_WIDTH  bin imaginary part, valid 1 cycle after rd_en
tx_data  output  8  byte to UART TX
tx_valid  output  1  tx_data valid; held until accepted
tx_ready  input  1  TX can accept; transfer when tx_valid && tx_ready
busy  output  1  high in every state except RX_FILL
frame_err  output  1  one-cycle pulse on timeout abort
state_o  output  3  current state encoding (debug)

Behaviour:
- Reset: state RX_FILL. All outputs 0: wr_en, fft_start, rd_en, tx_valid, frame_err, busy, addresses, data, state_o. All counters 0.
- State encodings: RX_FILL=0, START=1, WAIT_FFT=2, READ=3, LATCH=4, SEND=5.
- RX_FILL:
  - Each rx_valid toggles byte_idx. The first byte is the low byte and is held.
  - On the second byte, wr_en=1 for exactly the next cycle, with wr_addr=sample count and wr_data={byte1, byte0}. The sample count then increments.
  - After the write at address N-1, go to START.
- START: fft_start=1 for one cycle, then go to WAIT_FFT.
- WAIT_FFT: wait for fft_done=1, then go to READ with k=0.
- READ: rd_en=1 and rd_addr=k for one cycle, then go to LATCH.
- LATCH:
  - Capture rd_re and rd_im, each sign-extended to 32 bits, into a 64-bit shift register.
  - Byte order is re[7:0], re[15:8], re[23:16], re[31:24], then the same for im.
  - Go to SEND.
- SEND:
  - tx_valid=1 with tx_data equal to the current byte. tx_data must not change while tx_valid && !tx_ready.
  - On transfer, advance to the next byte. The next byte may be presented the following cycle.
  - After the 8th transfer, k increments. If k was N-1, go to RX_FILL with counters cleared; otherwise go to READ.
- rx_valid outside RX_FILL: ignored, bytes dropped, no error raised.
- RX timeout:
  - Applies only in RX_FILL with a partial frame (sample count≠0 or byte_idx≠0).
  - An idle counter clears on rx_valid. When it reaches RX_TIMEOUT, frame_err pulses, the partial frame is discarded, and the counters clear.
  - An empty RX_FILL never times out.
- FFT timeout: FFT_TIMEOUT cycles in WAIT_FFT causes a frame_err pulse and a return to RX_FILL.
- If fft_done and the timeout coincide, fft_done wins.
- rx_valid on the same cycle as the final write: the new byte is dropped, because the state is already leaving RX_FILL.
- Asynchronous reset mid-frame or mid-send immediately returns all outputs to their reset values. Any partial byte on TX is abandoned (tx_valid drops).
- Wrap: k and the sample count are ADDR_W+1 bits wide; comparisons use N-1, never overflow.

Test Plan:
(bench with N=8, ADDR_W=3, RX_TIMEOUT=100, FFT_TIMEOUT=200)
1. Send 16 bytes 0x01,0x00,0x02,0x00,...,0x08,0x00 -> 8 wr_en pulses, addr 0..7, data 0x0001..0x0008, then one fft_start pulse; busy rises.
2. Assert fft_done after 50 cycles; model returns re=26'h3FFFFFF, im=26'h0000005 for every bin; hold tx_ready=1 -> 64 tx bytes. Each bin sends FF FF FF FF 05 00 00 00, and rd_addr steps 0..7.
3. Same run with tx_ready toggling 1-of-3 cycles -> identical byte sequence; tx_data stable during every stall; no byte lost or duplicated.
4. Send 5 bytes, then stay idle for 100 cycles -> one frame_err pulse and no fft_start. A following full 16-byte frame writes addr 0..7 correctly.
5. Full frame with fft_done never asserted -> frame_err after 200 cycles in WAIT_FFT, state_o=0, no rd_en.
6. Assert RST during SEND of bin 3 -> tx_valid=0 and state_o=0 immediately. A fresh frame then completes normally with 64 bytes.
